// File: rtl/sonar_seq_pkg.sv
// Shared state encoding and default geometry for the sonar sample sequencer.
package sonar_seq_pkg;

  localparam int unsigned NUM_CH_DEF = 4;
  localparam int unsigned CH_W_DEF   = 2;
  localparam int unsigned DIV_W_DEF  = 8;
  localparam int unsigned CNT_W_DEF  = 16;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARM      = 3'd1,
    RUN      = 3'd2,
    WAIT_ADC = 3'd3,
    FINISH   = 3'd4
  } seq_state_e;

endpackage

// File: rtl/sonar_sample_sequencer_if.sv
// Host/ADC-side bundle of the sonar sample sequencer.
// SONAR_SEQ_OVERRUN_EN adds the sticky overrun flag.
interface sonar_sample_sequencer_if
  import sonar_seq_pkg::*;
#(
  parameter int unsigned CH_W  = CH_W_DEF,
  parameter int unsigned DIV_W = DIV_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
);
  logic             start;
  logic             abort;
  logic [DIV_W-1:0] div_value;
  logic [CNT_W-1:0] num_samples;
  logic             adc_ready;
  logic             tff_enable;
  logic             tff_d;
  logic [CH_W-1:0]  ch_sel;
  logic             sample_stb;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] sample_cnt;
`ifdef SONAR_SEQ_OVERRUN_EN
  logic             overrun;

  modport master (output start, abort, div_value, num_samples, adc_ready,
                  input  tff_enable, tff_d, ch_sel, sample_stb, busy, done, sample_cnt, overrun);
  modport slave  (input  start, abort, div_value, num_samples, adc_ready,
                  output tff_enable, tff_d, ch_sel, sample_stb, busy, done, sample_cnt, overrun);
`else
  modport master (output start, abort, div_value, num_samples, adc_ready,
                  input  tff_enable, tff_d, ch_sel, sample_stb, busy, done, sample_cnt);
  modport slave  (input  start, abort, div_value, num_samples, adc_ready,
                  output tff_enable, tff_d, ch_sel, sample_stb, busy, done, sample_cnt);
`endif
endinterface

// File: rtl/sonar_tick_gen.sv
// Programmable divider: one registered tick every div_lat+1 cycles while run is high.
module sonar_tick_gen #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             run,
  input  logic [DIV_W-1:0] div_lat,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (!run) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == div_lat) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + DIV_W'(1);
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/sonar_sample_sequencer.sv
// Acquisition-frame sequencer: TFF toggle pulses plus round-robin ADC strobes.
// SONAR_SEQ_OVERRUN_EN enables the sticky overrun output.
module sonar_sample_sequencer
  import sonar_seq_pkg::*;
#(
  parameter int unsigned NUM_CH = NUM_CH_DEF,
  parameter int unsigned CH_W   = CH_W_DEF,
  parameter int unsigned DIV_W  = DIV_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input logic                      clk,
  input logic                      resetn,
  sonar_sample_sequencer_if.slave  bus
);

  seq_state_e       state, state_n;
  logic [DIV_W-1:0] div_lat, div_lat_n;
  logic [CNT_W-1:0] num_lat, num_lat_n, cnt_q, cnt_n;
  logic [CH_W-1:0]  ch_idx, ch_idx_n, ch_q, ch_q_n;
  logic             tff_q, tff_n, stb_q, stb_n, busy_q, done_q, done_n;
  logic             tick, run_c, issue_c;
  logic [CNT_W-1:0] cnt_inc_c;
  logic [CH_W-1:0]  ch_inc_c;
`ifdef SONAR_SEQ_OVERRUN_EN
  logic             ovr_q, ovr_n;
`endif

  assign run_c     = (state == RUN) || (state == WAIT_ADC);
  assign cnt_inc_c = cnt_q + CNT_W'(1);
  assign ch_inc_c  = (ch_idx == CH_W'(NUM_CH - 1)) ? '0 : ch_idx + CH_W'(1);

  sonar_tick_gen #(.DIV_W(DIV_W)) u_tick (
    .clk     (clk),
    .resetn  (resetn),
    .run     (run_c),
    .div_lat (div_lat),
    .tick    (tick)
  );

  // Next-state and next-output decode; abort pre-empts any same-cycle tick or strobe.
  always_comb begin
    state_n   = state;
    div_lat_n = div_lat;
    num_lat_n = num_lat;
    cnt_n     = cnt_q;
    ch_idx_n  = ch_idx;
    ch_q_n    = ch_q;
    tff_n     = 1'b0;
    stb_n     = 1'b0;
    done_n    = 1'b0;
    issue_c   = 1'b0;
`ifdef SONAR_SEQ_OVERRUN_EN
    ovr_n     = ovr_q;
`endif
    case (state)
      IDLE: begin
        if (bus.start) begin
          div_lat_n = bus.div_value;
          num_lat_n = bus.num_samples;
          cnt_n     = '0;
          ch_idx_n  = '0;
          ch_q_n    = '0;
`ifdef SONAR_SEQ_OVERRUN_EN
          ovr_n     = 1'b0;
`endif
          state_n   = ARM;
        end
      end
      ARM: begin
        if (bus.abort || (num_lat == '0)) state_n = FINISH;
        else                              state_n = RUN;
      end
      RUN: begin
        if (bus.abort) begin
          state_n = FINISH;
        end else if (tick) begin
          tff_n = 1'b1;
          if (bus.adc_ready) issue_c = 1'b1;
          else               state_n = WAIT_ADC;
        end
      end
      WAIT_ADC: begin
        if (bus.abort) begin
          state_n = FINISH;
        end else begin
          if (tick) begin
            tff_n = 1'b1;
`ifdef SONAR_SEQ_OVERRUN_EN
            ovr_n = 1'b1;
`endif
          end
          if (bus.adc_ready) issue_c = 1'b1;
        end
      end
      FINISH: begin
        state_n = IDLE;
        done_n  = 1'b1;
      end
      default: state_n = IDLE;
    endcase
    // ch_sel shows the channel being strobed; ch_idx already points at the next one.
    if (issue_c) begin
      stb_n    = 1'b1;
      cnt_n    = cnt_inc_c;
      ch_q_n   = ch_idx;
      ch_idx_n = ch_inc_c;
      state_n  = (cnt_inc_c == num_lat) ? FINISH : RUN;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      div_lat <= '0;
      num_lat <= '0;
      cnt_q   <= '0;
      ch_idx  <= '0;
      ch_q    <= '0;
      tff_q   <= 1'b0;
      stb_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SONAR_SEQ_OVERRUN_EN
      ovr_q   <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      div_lat <= div_lat_n;
      num_lat <= num_lat_n;
      cnt_q   <= cnt_n;
      ch_idx  <= ch_idx_n;
      ch_q    <= ch_q_n;
      tff_q   <= tff_n;
      stb_q   <= stb_n;
      busy_q  <= (state_n != IDLE);
      done_q  <= done_n;
`ifdef SONAR_SEQ_OVERRUN_EN
      ovr_q   <= ovr_n;
`endif
    end
  end

  assign bus.tff_enable = tff_q;
  assign bus.tff_d      = tff_q;
  assign bus.sample_stb = stb_q;
  assign bus.ch_sel     = ch_q;
  assign bus.sample_cnt = cnt_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
`ifdef SONAR_SEQ_OVERRUN_EN
  assign bus.overrun    = ovr_q;
`endif

endmodule

// File: tb/tb_sonar_sample_sequencer.sv
// Scoreboard bench for sonar_sample_sequencer: directed frames, expected pulses queued by cycle.
module tb_sonar_sample_sequencer;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  sonar_sample_sequencer_if bus ();

  sonar_sample_sequencer dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    int rel;
    int ch;
    int cnt;
  } exp_t;

  exp_t q_stb[$];
  exp_t q_done[$];
  int   q_tff[$];
  exp_t me;
  int   cyc = 0;
  int   start_cyc = 0;
  int   busy_len = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Expected pulses are keyed by posedge index relative to the accepting edge.
  always @(negedge clk) begin
    if (resetn) begin
      if (bus.tff_enable) begin
        chk("tff_d", longint'(bus.tff_d), 1);
        if (q_tff.size() == 0) chk("tff_unexpected", cyc - start_cyc, -1);
        else                   chk("tff_cycle", cyc - start_cyc, q_tff.pop_front());
      end
      if (bus.sample_stb) begin
        if (q_stb.size() == 0) begin
          chk("stb_unexpected", cyc - start_cyc, -1);
        end else begin
          me = q_stb.pop_front();
          chk("stb_cycle", cyc - start_cyc, me.rel);
          chk("stb_ch", longint'(bus.ch_sel), me.ch);
          chk("stb_cnt", longint'(bus.sample_cnt), me.cnt);
        end
      end
      if (bus.done) begin
        if (q_done.size() == 0) begin
          chk("done_unexpected", cyc - start_cyc, -1);
        end else begin
          me = q_done.pop_front();
          chk("done_cycle", cyc - start_cyc, me.rel);
          chk("done_cnt", longint'(bus.sample_cnt), me.cnt);
        end
      end
      if (bus.busy) busy_len++;
    end
  end

  task automatic push_pulse(input int rel, input int ch, input int cnt, input bit strobe);
    exp_t e;
    q_tff.push_back(rel);
    if (strobe) begin
      e.rel = rel; e.ch = ch; e.cnt = cnt;
      q_stb.push_back(e);
    end
  endtask

  task automatic push_done(input int rel, input int cnt);
    exp_t e;
    e.rel = rel; e.ch = 0; e.cnt = cnt;
    q_done.push_back(e);
  endtask

  task automatic start_frame(input int div, input int num);
    @(negedge clk);
    busy_len         = 0;
    bus.div_value    = 8'(div);
    bus.num_samples  = 16'(num);
    bus.start        = 1'b1;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    bus.start = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(posedge clk);
      #2;
      if (bus.done) seen = 1'b1;
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  task automatic end_checks(input int exp_busy);
    @(negedge clk);
    #1;
    chk("busy_len", busy_len, exp_busy);
    chk("busy_after", longint'(bus.busy), 0);
    chk("stb_left", q_stb.size(), 0);
    chk("tff_left", q_tff.size(), 0);
    chk("done_left", q_done.size(), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_tff_enable"}, longint'(bus.tff_enable), 0);
    chk({tag, "_tff_d"}, longint'(bus.tff_d), 0);
    chk({tag, "_sample_stb"}, longint'(bus.sample_stb), 0);
    chk({tag, "_ch_sel"}, longint'(bus.ch_sel), 0);
    chk({tag, "_busy"}, longint'(bus.busy), 0);
    chk({tag, "_done"}, longint'(bus.done), 0);
    chk({tag, "_sample_cnt"}, longint'(bus.sample_cnt), 0);
  endtask

  initial begin
    bus.start       = 1'b0;
    bus.abort       = 1'b0;
    bus.div_value   = '0;
    bus.num_samples = '0;
    bus.adc_ready   = 1'b1;
    #3;
    chk_all_zero("reset");
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    // div=3, num=8: pulse every 4 clk starting 6 edges after accept; channels wrap
    for (int k = 0; k < 8; k++) push_pulse(6 + 4 * k, k % 4, k + 1, 1'b1);
    push_done(35, 8);
    start_frame(3, 8);
    wait_done();
    end_checks(35);
    chk("t1_sample_cnt", longint'(bus.sample_cnt), 8);
`ifdef SONAR_SEQ_OVERRUN_EN
    chk("t1_overrun", longint'(bus.overrun), 0);
`endif

    // num=0: no-op frame, busy for ARM and FINISH only
    push_done(2, 0);
    start_frame(3, 0);
    wait_done();
    end_checks(2);

    // div=2, adc_ready low over the 2nd tick for 5 cycles: deferred strobe, extra tick dropped
    push_pulse(5, 0, 1, 1'b1);
    push_pulse(8, 0, 0, 1'b0);
    push_pulse(11, 0, 0, 1'b0);
    q_stb.push_back('{rel: 13, ch: 1, cnt: 2});
    push_pulse(14, 2, 3, 1'b1);
    push_pulse(17, 3, 4, 1'b1);
    push_done(18, 4);
    start_frame(2, 4);
    repeat (7) @(posedge clk);
    @(negedge clk);
    bus.adc_ready = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    bus.adc_ready = 1'b1;
    wait_done();
    end_checks(18);
`ifdef SONAR_SEQ_OVERRUN_EN
    chk("t3_overrun", longint'(bus.overrun), 1);
`endif

    // abort on the 3rd tick cycle: no pulse, FINISH next, count holds at 2
    push_pulse(6, 0, 1, 1'b1);
    push_pulse(10, 1, 2, 1'b1);
    push_done(15, 2);
    start_frame(3, 8);
    repeat (13) @(posedge clk);
    @(negedge clk);
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    wait_done();
    end_checks(15);
    repeat (3) @(posedge clk);
    #2;
    chk("t4_cnt_hold", longint'(bus.sample_cnt), 2);
`ifdef SONAR_SEQ_OVERRUN_EN
    chk("t4_overrun_cleared", longint'(bus.overrun), 0);
`endif

    // asynchronous reset mid-frame, then a clean div=1 num=5 frame
    push_pulse(6, 0, 1, 1'b1);
    start_frame(3, 8);
    repeat (8) @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    chk_all_zero("async_rst");
    chk("rst_stb_left", q_stb.size(), 0);
    q_stb.delete();
    q_tff.delete();
    q_done.delete();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    for (int k = 0; k < 5; k++) push_pulse(4 + 2 * k, k % 4, k + 1, 1'b1);
    push_done(13, 5);
    start_frame(1, 5);
    wait_done();
    end_checks(13);

    // div=0: TFF on 3 consecutive cycles; start while busy is ignored
    for (int k = 0; k < 3; k++) push_pulse(3 + k, k, k + 1, 1'b1);
    push_done(6, 3);
    start_frame(0, 3);
    @(posedge clk);
    @(negedge clk);
    bus.div_value   = 8'd5;
    bus.num_samples = 16'd1;
    bus.start       = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done();
    end_checks(6);
    repeat (20) @(posedge clk);
    #2;
    chk("t6_idle_busy", longint'(bus.busy), 0);
    chk("t6_cnt_final", longint'(bus.sample_cnt), 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
